// File: rtl/grid_player_mover.sv
// grid_player_mover: tile-aligned player movement with buffered turns and mid-tile reversal.
// Define WRAP_TUNNEL_EN to let the player wrap between column 0 and column COLS-1.

`ifndef Dir_up
`define Dir_up    2'd0
`endif
`ifndef Dir_left
`define Dir_left  2'd1
`endif
`ifndef Dir_down
`define Dir_down  2'd2
`endif
`ifndef Dir_right
`define Dir_right 2'd3
`endif

module grid_player_mover #(
  parameter int         TILE_SIZE = 20,
  parameter int         COLS      = 32,
  parameter int         ROWS      = 24,
  parameter int         STEP      = 4,
  parameter int         START_COL = 1,
  parameter int         START_ROW = 1,
  parameter logic [1:0] START_DIR = `Dir_left
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  tick,
  input  logic                                  w,
  input  logic                                  a,
  input  logic                                  s,
  input  logic                                  d,
  input  logic [ROWS*COLS-1:0]                  tilemap_walls,
  output logic [$clog2(COLS*TILE_SIZE)-1:0]     pos_x,
  output logic [$clog2(ROWS*TILE_SIZE)-1:0]     pos_y,
  output logic [$clog2(COLS)-1:0]               tile_col,
  output logic [$clog2(ROWS)-1:0]               tile_row,
  output logic [1:0]                            player_direction,
  output logic                                  moving,
  output logic                                  tile_enter
);

  localparam int X_W   = $clog2(COLS*TILE_SIZE);
  localparam int Y_W   = $clog2(ROWS*TILE_SIZE);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int OFF_W = $clog2(TILE_SIZE);
  localparam int IDX_W = $clog2(ROWS*COLS);

  localparam logic [1:0] DIR_UP    = `Dir_up;
  localparam logic [1:0] DIR_LEFT  = `Dir_left;
  localparam logic [1:0] DIR_DOWN  = `Dir_down;
  localparam logic [1:0] DIR_RIGHT = `Dir_right;

  typedef enum logic {ST_STOP, ST_MOVE} state_t;

  state_t state_reg, state_next;

  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [OFF_W-1:0] off_x_reg, off_x_next;
  logic [OFF_W-1:0] off_y_reg, off_y_next;
  logic [X_W-1:0]   pos_x_reg, pos_x_next;
  logic [Y_W-1:0]   pos_y_reg, pos_y_next;
  logic [1:0]       dir_reg, dir_next;
  logic [1:0]       pend_dir_reg, pend_dir_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             tile_enter_reg, tile_enter_next;

  logic       aligned;
  logic       pend_free;
  logic       cur_free;
  logic       advance;
  logic       take_turn;
  logic [1:0] move_dir;
  logic       key_hit;
  logic [1:0] key_dir;

  // Free test for the tile adjacent to (col,row); off-grid tiles are walls unless tunnel wrap applies.
  function automatic logic neighbour_free(input logic [1:0]           dir,
                                          input logic [COL_W-1:0]     col,
                                          input logic [ROW_W-1:0]     row,
                                          input logic [ROWS*COLS-1:0] walls);
    int               nc;
    int               nr;
    logic             ok;
    logic [IDX_W-1:0] idx;
    nc = int'(col);
    nr = int'(row);
    ok = 1'b1;
    case (dir)
      DIR_UP: begin
        if (nr == 0) ok = 1'b0;
        else nr = nr - 1;
      end
      DIR_DOWN: begin
        if (nr == ROWS-1) ok = 1'b0;
        else nr = nr + 1;
      end
      DIR_LEFT: begin
        if (nc == 0) begin
`ifdef WRAP_TUNNEL_EN
          nc = COLS - 1;
`else
          ok = 1'b0;
`endif
        end else begin
          nc = nc - 1;
        end
      end
      default: begin
        if (nc == COLS-1) begin
`ifdef WRAP_TUNNEL_EN
          nc = 0;
`else
          ok = 1'b0;
`endif
        end else begin
          nc = nc + 1;
        end
      end
    endcase
    idx = IDX_W'(nr*COLS + nc);
    return ok && !walls[idx];
  endfunction

  // Newest key wins; simultaneous presses resolve w > s > a > d.
  always_comb begin
    key_hit = 1'b1;
    key_dir = dir_reg;
    if (!w)      key_dir = DIR_UP;
    else if (!s) key_dir = DIR_DOWN;
    else if (!a) key_dir = DIR_LEFT;
    else if (!d) key_dir = DIR_RIGHT;
    else         key_hit = 1'b0;
  end

  // Junction decision at aligned positions, reversal-only decision mid-tile.
  always_comb begin
    aligned   = (off_x_reg == '0) && (off_y_reg == '0);
    pend_free = neighbour_free(pend_dir_reg, col_reg, row_reg, tilemap_walls);
    cur_free  = neighbour_free(dir_reg, col_reg, row_reg, tilemap_walls);
    advance   = 1'b0;
    take_turn = 1'b0;
    move_dir  = dir_reg;
    if (aligned) begin
      if (pend_valid_reg && pend_free) begin
        take_turn = 1'b1;
        move_dir  = pend_dir_reg;
        advance   = 1'b1;
      end else if (cur_free) begin
        advance = 1'b1;
      end
    end else begin
      advance = 1'b1;
      if (pend_valid_reg && (pend_dir_reg == (dir_reg ^ 2'b10))) begin
        take_turn = 1'b1;
        move_dir  = pend_dir_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_STOP;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (tick) state_next = advance ? ST_MOVE : ST_STOP;
  end

  always_comb begin
    int cn;
    int rn;
    int ox;
    int oy;
    cn = int'(col_reg);
    rn = int'(row_reg);
    ox = int'(off_x_reg);
    oy = int'(off_y_reg);
    dir_next        = dir_reg;
    tile_enter_next = 1'b0;
    pend_dir_next   = pend_dir_reg;
    pend_valid_next = pend_valid_reg;
    if (tick && advance) begin
      dir_next = move_dir;
      case (move_dir)
        DIR_RIGHT: begin
          ox = ox + STEP;
          if (ox == TILE_SIZE) begin
            ox = 0;
            cn = (cn == COLS-1) ? 0 : cn + 1;
          end
        end
        DIR_DOWN: begin
          oy = oy + STEP;
          if (oy == TILE_SIZE) begin
            oy = 0;
            rn = rn + 1;
          end
        end
        DIR_LEFT: begin
          if (ox == 0) begin
            ox = TILE_SIZE - STEP;
            cn = (cn == 0) ? COLS - 1 : cn - 1;
          end else begin
            ox = ox - STEP;
          end
        end
        default: begin
          if (oy == 0) begin
            oy = TILE_SIZE - STEP;
            rn = rn - 1;
          end else begin
            oy = oy - STEP;
          end
        end
      endcase
      tile_enter_next = (ox == 0) && (oy == 0);
    end
    // A fresh key press outranks clearing the turn just taken; it is seen on the next tick.
    if (key_hit) begin
      pend_dir_next   = key_dir;
      pend_valid_next = 1'b1;
    end else if (tick && take_turn) begin
      pend_valid_next = 1'b0;
    end
    col_next   = COL_W'(cn);
    row_next   = ROW_W'(rn);
    off_x_next = OFF_W'(ox);
    off_y_next = OFF_W'(oy);
    pos_x_next = X_W'(cn*TILE_SIZE + ox);
    pos_y_next = Y_W'(rn*TILE_SIZE + oy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_reg        <= COL_W'(START_COL);
      row_reg        <= ROW_W'(START_ROW);
      off_x_reg      <= '0;
      off_y_reg      <= '0;
      pos_x_reg      <= X_W'(START_COL*TILE_SIZE);
      pos_y_reg      <= Y_W'(START_ROW*TILE_SIZE);
      dir_reg        <= START_DIR;
      pend_dir_reg   <= START_DIR;
      pend_valid_reg <= 1'b0;
      tile_enter_reg <= 1'b0;
    end else begin
      col_reg        <= col_next;
      row_reg        <= row_next;
      off_x_reg      <= off_x_next;
      off_y_reg      <= off_y_next;
      pos_x_reg      <= pos_x_next;
      pos_y_reg      <= pos_y_next;
      dir_reg        <= dir_next;
      pend_dir_reg   <= pend_dir_next;
      pend_valid_reg <= pend_valid_next;
      tile_enter_reg <= tile_enter_next;
    end
  end

  assign pos_x            = pos_x_reg;
  assign pos_y            = pos_y_reg;
  assign tile_col         = col_reg;
  assign tile_row         = row_reg;
  assign player_direction = dir_reg;
  assign moving           = (state_reg == ST_MOVE);
  assign tile_enter       = tile_enter_reg;

endmodule

// File: doc/grid_player_mover.md
Name: grid_player_mover

Overview:
- Tile-aligned player movement controller for the PAC-MAN playfield. Generalised successor to the fixed-speed player controller.
- Parametrised grid size, tile size and sub-tile step. Movement is paced by a tick enable.
- Buffers turn requests until the next free junction, allows instant reversal mid-tile, and wraps through the horizontal tunnel.
- Sits between keypad inputs and the sprite renderer. Drives dot-eating logic with a tile-entry strobe.

Parameters:
- TILE_SIZE, 20, tile edge in pixels.
- COLS, 32, tiles per row.
- ROWS, 24, tiles per column.
- STEP, 4, pixels moved per tick. Must divide TILE_SIZE.
- START_COL, 1, reset tile column.
- START_ROW, 1, reset tile row.
- START_DIR, `dir_left, reset facing direction.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  movement enable, one-cycle pulse.
- w  in  1  up key, active-low.
- a  in  1  left key, active-low.
- s  in  1  down key, active-low.
- d  in  1  right key, active-low.
- tilemap_walls  in  ROWS*COLS  wall bitmap, bit index row*COLS+col, 1 = wall.
- pos_x  out  $clog2(COLS*TILE_SIZE)  pixel x of sprite top-left.
- pos_y  out  $clog2(ROWS*TILE_SIZE)  pixel y of sprite top-left.
- tile_col  out  $clog2(COLS)  current tile column.
- tile_row  out  $clog2(ROWS)  current tile row.
- player_direction  out  2  facing direction, `dir_* encoding.
- moving  out  1  1 while in MOVE.
- tile_enter  out  1  one-cycle strobe on arrival at a tile-aligned position.

Behaviour:
- Reset is synchronous and active-high, sampled on the clk rising edge. Reset values:
  - tile_col = START_COL, tile_row = START_ROW.
  - Sub-tile offsets = 0.
  - player_direction = START_DIR.
  - Pending-turn valid = 0.
  - State = STOP, moving = 0, tile_enter = 0.
- Reset asserted mid-move discards the move and any pending turn.
- Position model:
  - pos_x = tile_col*TILE_SIZE + off_x.
  - pos_y = tile_row*TILE_SIZE + off_y.
  - Offsets range 0..TILE_SIZE-STEP. At most one offset is nonzero.
  - "Aligned" means both offsets are 0.
- Key sampling:
  - Keys are sampled every cycle, independent of tick.
  - Any key low latches the pending direction and sets pending-valid.
  - Priority when several keys are low: w > s > a > d.
  - A newer key press overwrites the pending direction.
  - Pending is cleared only when the turn is taken.
- Neighbour test at aligned position (col,row):
  - up = row-1, down = row+1, left = col-1, right = col+1.
  - A neighbour is free if its bit is 0.
  - A neighbour outside the grid counts as a wall, except where tunnel wrap applies.
- FSM is updated only on cycles with tick=1; all outputs are registered.
- STOP state (always aligned):
  - If pending is valid and the pending neighbour is free: player_direction <= pending, clear pending, take one step, go to MOVE.
  - Else, if the current-direction neighbour is free: take one step, go to MOVE.
  - Else: stay in STOP.
- MOVE state, not aligned, on tick:
  - If pending is the opposite of player_direction: reverse immediately, clear pending, then step.
  - Otherwise: step in player_direction.
  - Other pending turns remain buffered.
- Step arithmetic for right/down:
  - off += STEP.
  - When off reaches TILE_SIZE: off = 0 and col/row increments.
- Step arithmetic for left/up:
  - If off == 0: col/row decrements and off = TILE_SIZE-STEP.
  - Else: off -= STEP.
- Arrival and junction decisions:
  - When a step results in aligned, tile_enter = 1 on that same registered cycle.
  - On the next tick, the STOP-state rules apply (evaluated directly from MOVE).
  - If no free neighbour exists, go to STOP with moving = 0.
- tile_enter is 0 on every cycle other than arrival.
- With TILE_SIZE/STEP = 5, one tile takes 5 ticks.
- Simultaneous key change and tick in the same cycle: the decision uses the pending value registered before that edge, so the new key is seen on the next tick.

Optional Feature:
- WRAP_TUNNEL_EN defined:
  - Aligned at col 0 facing left: the left neighbour is (COLS-1,row). Moving off col 0 sets tile_col = COLS-1, off_x = TILE_SIZE-STEP.
  - Aligned at col COLS-1 facing right: the right neighbour is (0,row). Crossing sets tile_col = 0.
  - Wall bits of the wrapped tile still apply.
- Undefined: out-of-grid columns are walls, and the player stops at the edge.

Test Plan:
- Reset with START_COL=1, START_ROW=1, open corridor to the left:
  - Reset high for 2 cycles gives pos=(20,20), dir=left, moving=0.
  - First tick after release gives pos_x=16, moving=1.
- Open horizontal corridor, no keys, 5 ticks:
  - pos_x goes 16,12,8,4,0 and tile_col=0.
  - tile_enter pulses exactly once, on the 5th tick.
- Early turn request at (3,1) moving right, up blocked at col 4, free at col 5:
  - Press w for 1 cycle at pos_x=64, then 10 ticks.
  - Passes col 4 without turning; turns up at col 5.
  - pending clears, dir=up.
- Mid-tile reversal: moving right at off_x=8, press a then tick:
  - off_x=4, dir=left.
  - 1 more tick gives aligned at the original column with tile_enter=1.
- Dead end: wall ahead and all keyed directions walled:
  - On the arrival tick plus 1, moving=0 and position is held for 20 further ticks.
- Reset while at off_y=12 with a pending turn:
  - Returns to the START position, dir=START_DIR, pending cleared, tile_enter=0.
- Tunnel, COLS=32, at col 0 facing left, left-edge tile free:
  - With WRAP_TUNNEL_EN: tile_col=31, pos_x=636.
  - Without it: state STOP, pos_x=0.
